// File: rtl/imem_responder.sv
// Byte-wide instruction store returning big-endian words LATENCY+1 cycles after accept (one-cycle rsp_valid pulse).
// Non-pipelined: req_ready only in IDLE and never while a load byte is offered; ld_ready only in IDLE.
module imem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [31:0]       req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_misaligned,
  input  logic              ld_start,
  input  logic              ld_en,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  output logic [ADDR_W-1:0] ld_ptr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] LAT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              mis_q;
  logic [7:0]        mem [DEPTH];

  logic              accept;
  logic              load;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_a0, rd_a1, rd_a2, rd_a3;
  logic [31:0]       rd_word;
  logic              unused_addr_hi;

  assign ld_ready  = (state == IDLE);
  assign req_ready = (state == IDLE) && !ld_en;
  assign accept    = req_valid && req_ready;
  assign load      = ld_en && ld_ready;
  assign wr_addr   = ld_start ? '0 : ld_ptr;

  // With zero latency the word is read in the accept cycle, straight from the request address.
  assign rd_a0   = (state == IDLE) ? req_addr[ADDR_W-1:0] : addr_q;
  assign rd_a1   = rd_a0 + ADDR_W'(1);
  assign rd_a2   = rd_a0 + ADDR_W'(2);
  assign rd_a3   = rd_a0 + ADDR_W'(3);
  assign rd_word = {mem[rd_a0], mem[rd_a1], mem[rd_a2], mem[rd_a3]};

  assign unused_addr_hi = ^req_addr[31:ADDR_W];

  always_ff @(posedge clk) begin
    if (load) mem[wr_addr] <= ld_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      addr_q         <= '0;
      mis_q          <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_misaligned <= 1'b0;
      ld_ptr         <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_start)   ld_ptr <= ld_en ? ADDR_W'(1) : '0;
          else if (ld_en) ld_ptr <= ld_ptr + ADDR_W'(1);
          if (accept) begin
            addr_q <= req_addr[ADDR_W-1:0];
            mis_q  <= |req_addr[1:0];
            if (LATENCY == 0) begin
              state          <= RESP;
              rsp_valid      <= 1'b1;
              rsp_data       <= rd_word;
              rsp_misaligned <= |req_addr[1:0];
            end else begin
              state <= WAIT;
              cnt   <= LAT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state          <= RESP;
            rsp_valid      <= 1'b1;
            rsp_data       <= rd_word;
            rsp_misaligned <= mis_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
Instruction-memory responder serving the fetch side of the multicycle CPU over a valid/ready request and single-cycle response handshake. It holds a byte-wide instruction store and returns big-endian 32-bit words after a programmable wait latency. A byte-serial program-load port fills the store between fetches, so firmware is loaded by hardware rather than by simulation preload only.

Parameters:
ADDR_W, 10, byte-address bits of the store (2^ADDR_W bytes; default 1024)
LATENCY, 2, wait cycles between request acceptance and response (legal 0..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
req_valid  in  1  fetch request present
req_addr  in  32  byte address of fetch; only [ADDR_W-1:0] used (0x0000_3000 maps to offset 0)
req_ready  out  1  responder can accept request this cycle
rsp_valid  out  1  response word valid, one-cycle pulse
rsp_data  out  32  fetched word
rsp_misaligned  out  1  req_addr[1:0] != 0 for this response
ld_start  in  1  reset load pointer to 0
ld_en  in  1  write ld_byte at load pointer
ld_byte  in  8  load data
ld_ready  out  1  load write accepted this cycle
ld_ptr  out  ADDR_W  current load pointer

Behaviour:
- Reset (async): state IDLE; rsp_valid=0, rsp_data=0, rsp_misaligned=0, ld_ptr=0, wait counter=0. Store contents are not cleared. Reset mid-fetch aborts the fetch; no response is ever issued for it.
- States: IDLE, WAIT, RESP.
- ld_ready = (state==IDLE), combinational.
- req_ready = (state==IDLE) && !ld_en, combinational; a load in the same cycle wins over a fetch.
- IDLE: on req_valid && req_ready at edge E0:
  - latch req_addr[ADDR_W-1:0] and the misaligned flag;
  - go to WAIT with counter=LATENCY-1 if LATENCY>0, else go directly to RESP.
- WAIT: counter decrements each cycle; when counter==0, go to RESP at the next edge.
- RESP: lasts exactly one cycle; rsp_valid=1; then return to IDLE.
- Response timing: rsp_valid is high in the cycle following edge E0+LATENCY.
- Response data: rsp_data={m[a],m[a+1],m[a+2],m[a+3]}, big-endian, a = latched offset. Each byte address wraps modulo 2^ADDR_W. Data is sampled from the store on the edge entering RESP.
- rsp_data and rsp_misaligned hold their value after the pulse until the next response. Misaligned requests still return the wrapped data.
- Minimum request spacing: LATENCY+2 cycles; there is no pipelining.
- Load, in IDLE only:
  - ld_start sets ld_ptr=0.
  - ld_en writes ld_byte to m[ld_ptr] and ld_ptr increments, wrapping from 2^ADDR_W-1 to 0.
  - ld_start and ld_en in the same cycle: the byte is written at 0 and ld_ptr becomes 1.
  - ld_en or ld_start outside IDLE is ignored; the loader must hold until ld_ready.
- req_valid deasserting before acceptance is legal. The request is not latched until the handshake completes.

Test Plan:
- Reset, ld_start, then load bytes 3C,08,00,10 with ld_en -> ld_ptr=4. Request 0x0000_3000 (LATENCY=2) accepted at E0 -> rsp_valid high only in the cycle after E0+2, rsp_data=0x3C080010, rsp_misaligned=0.
- LATENCY=0 build: request accepted at E0 -> rsp_valid in the cycle after E0. Back-to-back requests -> second accepted exactly 2 cycles after the first.
- Wrap: load bytes at offsets 1022,1023,0,1 = AA,BB,CC,DD, then request offset 1022 -> rsp_data=0xAABBCCDD, rsp_misaligned=1.
- Collision: req_valid and ld_en high together in IDLE -> req_ready=0, byte written, request accepted the following cycle. ld_en during WAIT -> ignored, ld_ptr unchanged.
- Reset asserted during WAIT -> state IDLE immediately, rsp_valid never pulses, store contents preserved (re-fetch returns previously loaded word).
- ld_ptr wrap: 1024 ld_en writes from 0 -> ld_ptr=0. ld_start+ld_en same cycle with byte 0x55 -> m[0]=0x55, ld_ptr=1.
